avalon_stream_capture: RTL
==========================

// Module: avalon_stream_capture
// PURPOSE
//  Avalon-ST byte sink with an Avalon-MM CSR slave for readout. Accepts bytes
//  from a stream source (e.g. demo_avalon_memory aso_*), buffers them in a FIFO
//  and lets a host pop them through register reads. Bytes leave only through
//  host pops or flush. Sits on the same Avalon-MM host bus as the source block.
// PARAMETERS
//  FIFO_DEPTH     16  FIFO entries; power of 2, 4..256
//  AV_ADDRESS_W   2   CSR word address width
//  AV_DATA_W      32  CSR data width
//  ST_DATA_W      8   stream symbol width (<=16)
// PORTS
//  clk              in   1              system clock, all logic on rising edge
//  reset            in   1              asynchronous, active-high reset
//  asi_valid        in   1              stream data valid
//  asi_data         in   ST_DATA_W      stream data
//  asi_ready        out  1              sink ready (ready latency 0)
//  avs_write        in   1              CSR write strobe
//  avs_read         in   1              CSR read strobe
//  avs_waitrequest  out  1              CSR stall
//  avs_address      in   AV_ADDRESS_W   CSR word address
//  avs_byteenable   in   AV_DATA_W/8    write byte lanes
//  avs_writedata    in   AV_DATA_W      CSR write data
//  avs_readdata     out  AV_DATA_W      CSR read data, registered
// BEHAVIOUR
//  Reset: FIFO empty, ptrs/level 0, ENABLE=0, STALL=0, COUNT=0, readdata=0,
//   read FSM IDLE. Outputs while reset is high: asi_ready=0; waitrequest
//   follows its equation (=avs_read).
//  CSR map (word addr):
//   0 DATA  R: [31]=valid, [ST_DATA_W-1:0]=head byte, rest 0; pops if valid.
//           R on empty: 0, no pointer change. W: ignored.
//   1 STAT  R: [31]=full, [30]=empty, [16]=STALL sticky, [8:0]=level.
//           W with writedata[16]=1: clear STALL.
//   2 CTRL  R/W: [0]=ENABLE (byte lane 0 only). [1]=FLUSH, write-1
//           self-clearing, reads 0. Upper bits read 0.
//   3 COUNT R: accepted-byte count, 32-bit, wraps 0xFFFFFFFF->0.
//           W with any byteenable set: clear to 0.
//  Stream: asi_ready = ENABLE & !full & !flush_wr, where flush_wr is a CTRL
//   write with byte lane 0 enabled and writedata[1]=1 in the same cycle.
//   Transfer when asi_valid & asi_ready. Byte readable on the next cycle.
//   STALL set on asi_valid & ENABLE & full. Set wins over a same-cycle clear.
//  Read FSM: IDLE --avs_read--> RESP --> IDLE.
//   waitrequest = avs_read & (state==IDLE). Writes never stall.
//   In IDLE with avs_read: readdata and any DATA pop update at the edge.
//   In RESP: waitrequest=0, readdata held. Exactly one pop per read
//   transaction. A held avs_read starts a new transaction the cycle after RESP.
//  FIFO: level 0..FIFO_DEPTH, pointers wrap modulo FIFO_DEPTH.
//   Push+pop same cycle: level unchanged; both pointers advance.
//   Pop of the last entry plus push same cycle: the new byte becomes head.
//  Flush: at the write edge, ptrs and level go to 0. Any same-cycle push is
//   blocked (asi_ready=0). COUNT and STALL are not affected.
//  ENABLE=0 stops acceptance only; buffered bytes remain readable.
//  Reset mid-transaction: FSM returns to IDLE and all FIFO contents are lost.
// TESTING
//  1 Reset, write CTRL=1, stream 0x11,0x22,0x33 -> STAT level=3.
//    Three DATA reads return 0x80000011, 0x80000022, 0x80000033.
//    A fourth DATA read returns 0; STAT[30]=1.
//  2 Stream FIFO_DEPTH bytes with valid held, no reads -> asi_ready=0 after 16;
//    STAT=0x80010010 (full, STALL); one DATA pop -> asi_ready=1 next cycle.
//  3 Source with ready-delay 3 feeding 0x00..0x3F while host pops continuously
//    -> all 64 bytes read in order; COUNT=64; no duplicates, no drops.
//  4 Push 5 bytes, write CTRL=3 while asi_valid=1 -> level=0, that byte not
//    counted, COUNT=5. Then write STAT bit16, then COUNT -> both read 0.
//  5 Assert reset mid-read (FSM in RESP) with level=4 -> readdata=0, empty,
//    ENABLE=0, asi_ready=0. Read after reset sees 1 waitrequest cycle.
//  6 Preload COUNT to 0xFFFFFFFF via 2^32-1 accepted bytes (forced state in
//    sim); accept one more byte -> COUNT=0.

Source files
------------

// File: rtl/avalon_stream_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_stream_capture_if
//  Purpose  : Avalon-ST sink plus Avalon-MM CSR signal bundle for the
//             stream capture block. master = host/source side,
//             slave = capture block side.
//  Revision : 1.0  initial release
// ============================================================================
interface avalon_stream_capture_if #(
    parameter int AV_ADDRESS_W = 2,
    parameter int AV_DATA_W    = 32,
    parameter int ST_DATA_W    = 8
);
    logic                     asi_valid;
    logic [ST_DATA_W-1:0]     asi_data;
    logic                     asi_ready;
    logic                     avs_write;
    logic                     avs_read;
    logic                     avs_waitrequest;
    logic [AV_ADDRESS_W-1:0]  avs_address;
    logic [AV_DATA_W/8-1:0]   avs_byteenable;
    logic [AV_DATA_W-1:0]     avs_writedata;
    logic [AV_DATA_W-1:0]     avs_readdata;

    modport master (
        output asi_valid, asi_data,
        output avs_write, avs_read, avs_address, avs_byteenable, avs_writedata,
        input  asi_ready, avs_waitrequest, avs_readdata
    );

    modport slave (
        input  asi_valid, asi_data,
        input  avs_write, avs_read, avs_address, avs_byteenable, avs_writedata,
        output asi_ready, avs_waitrequest, avs_readdata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_stream_capture.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_stream_capture
//  Purpose  : Avalon-ST byte sink buffering symbols in a FIFO; an Avalon-MM
//             CSR slave lets the host pop bytes, watch level/stall status,
//             enable/flush the sink and read an accepted-byte counter.
//  Revision : 1.0  initial release
// ============================================================================
module avalon_stream_capture #(
    parameter int FIFO_DEPTH   = 16,
    parameter int AV_ADDRESS_W = 2,
    parameter int AV_DATA_W    = 32,
    parameter int ST_DATA_W    = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    avalon_stream_capture_if.slave  bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [AV_ADDRESS_W-1:0] c_ADDR_DATA  = AV_ADDRESS_W'(0);
    localparam logic [AV_ADDRESS_W-1:0] c_ADDR_STAT  = AV_ADDRESS_W'(1);
    localparam logic [AV_ADDRESS_W-1:0] c_ADDR_CTRL  = AV_ADDRESS_W'(2);
    localparam logic [AV_ADDRESS_W-1:0] c_ADDR_COUNT = AV_ADDRESS_W'(3);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_waitrequest;

    logic [ST_DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_LVL_W-1:0]     r_level;
    logic                   r_enable;
    logic                   r_stall;
    logic [31:0]            r_count;
    logic [AV_DATA_W-1:0]   r_readdata;
    logic [AV_DATA_W-1:0]   w_rdata;

    logic w_full;
    logic w_empty;
    logic w_flush_wr;
    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_rd_accept;
    logic w_stall_set;
    logic w_stall_clr;
    logic w_count_clr;

    assign w_full      = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_empty     = (r_level == '0);
    // Flush is decoded combinationally so a byte offered in the flush cycle is refused
    assign w_flush_wr  = bus.avs_write & (bus.avs_address == c_ADDR_CTRL)
                       & bus.avs_byteenable[0] & bus.avs_writedata[1];
    assign w_ready     = r_enable & ~w_full & ~w_flush_wr;
    assign w_push      = bus.asi_valid & w_ready;
    // A read is only acted upon in the IDLE cycle, giving one pop per transaction
    assign w_rd_accept = w_waitrequest;
    assign w_pop       = w_rd_accept & (bus.avs_address == c_ADDR_DATA) & ~w_empty & ~w_flush_wr;
    assign w_stall_set = bus.asi_valid & r_enable & w_full;
    assign w_stall_clr = bus.avs_write & (bus.avs_address == c_ADDR_STAT) & bus.avs_writedata[16];
    assign w_count_clr = bus.avs_write & (bus.avs_address == c_ADDR_COUNT) & (|bus.avs_byteenable);

    assign bus.asi_ready       = w_ready;
    assign bus.avs_waitrequest = w_waitrequest;
    assign bus.avs_readdata    = r_readdata;

    // Read FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Read FSM next state and waitrequest
    always_comb begin
        w_state_nxt   = r_state;
        w_waitrequest = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.avs_read) begin
                    w_waitrequest = 1'b1;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; no reset needed since level gates visibility
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.asi_data;
    end

    // FIFO pointers and level; flush empties the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush_wr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push & ~w_pop)      r_level <= r_level + c_LVL_W'(1);
            else if (~w_push & w_pop) r_level <= r_level - c_LVL_W'(1);
        end
    end

    // Control, sticky stall and accepted-byte counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable <= 1'b0;
            r_stall  <= 1'b0;
            r_count  <= '0;
        end else begin
            if (bus.avs_write && bus.avs_address == c_ADDR_CTRL && bus.avs_byteenable[0])
                r_enable <= bus.avs_writedata[0];
            if (w_stall_set)      r_stall <= 1'b1;
            else if (w_stall_clr) r_stall <= 1'b0;
            if (w_count_clr)      r_count <= '0;
            else if (w_push)      r_count <= r_count + 32'd1;
        end
    end

    // CSR read multiplexer
    always_comb begin
        w_rdata = '0;
        case (bus.avs_address)
            c_ADDR_DATA: begin
                if (!w_empty) begin
                    w_rdata[AV_DATA_W-1]   = 1'b1;
                    w_rdata[ST_DATA_W-1:0] = r_mem[r_rd_ptr];
                end
            end
            c_ADDR_STAT: begin
                w_rdata[31]        = w_full;
                w_rdata[30]        = w_empty;
                w_rdata[16]        = r_stall;
                w_rdata[c_PTR_W:0] = r_level;
            end
            c_ADDR_CTRL:  w_rdata[0]    = r_enable;
            default:      w_rdata[31:0] = r_count;
        endcase
    end

    // Registered read data, captured when a read is accepted and held in RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_readdata <= '0;
        else if (w_rd_accept) r_readdata <= w_rdata;
    end
endmodule
`default_nettype wire
